// File: rtl/reg_bus_defs.sv
// rtl/reg_bus_defs.sv - shared reg_if bus op codes, FSM states and register map
package reg_bus_defs;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_GAP   = 3'd5,
    S_RSP   = 3'd6
  } state_t;

endpackage

// File: rtl/reg_if_master.sv
// rtl/reg_if_master.sv - reg_if bus initiator: single write, read and poll commands
module reg_if_master
  import reg_bus_defs::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int POLL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic [POLL_WIDTH-1:0] cmd_limit,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic [POLL_WIDTH-1:0]   limit_q;
  logic [POLL_WIDTH-1:0]   retry_q;
  logic [1:0]              lat_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    err_q;
  logic                    accept;
  logic                    lat_done;
  logic                    match;
  logic                    limit_hit;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign lat_done  = (lat_q == LAT_LAST);
  assign match     = ((data_q & mask_q) == (wdata_q & mask_q));
  assign limit_hit = (retry_q == limit_q);

  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    wen       = 1'b0;
    ren       = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR:         state_nxt = S_WR;
            OP_RD, OP_POLL: state_nxt = S_RD;
            default:       state_nxt = S_RSP;
          endcase
        end
      end
      S_WR: begin
        wen       = 1'b1;
        state_nxt = S_RSP;
      end
      S_RD: begin
        ren       = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (lat_done) state_nxt = (op_q == OP_POLL) ? S_CHECK : S_RSP;
      S_CHECK: state_nxt = (match || limit_hit) ? S_RSP : S_GAP;
      S_GAP: state_nxt = S_RD;
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command latch, latency counter, retry counter and response data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_WR;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      limit_q <= '0;
      retry_q <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        mask_q  <= cmd_mask;
        limit_q <= cmd_limit;
        retry_q <= '0;
        data_q  <= '0;
        err_q   <= (cmd_op == OP_RSV);
      end
      if (state == S_RD) lat_q <= '0;
      if (state == S_WAIT) begin
        if (lat_done) data_q <= rdata;
        else          lat_q  <= lat_q + 2'd1;
      end
      // limit_hit is checked before the increment so the counter never wraps
      if (state == S_CHECK && !match) begin
        if (limit_hit) err_q   <= 1'b1;
        else           retry_q <= retry_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_if_master.sv
// tb/tb_reg_if_master.sv - scoreboard bench for reg_if_master with a behavioural reg_if slave
module tb_reg_if_master;
  import reg_bus_defs::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic [15:0] cmd_limit = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int hs_cnt = 0;
  int rise_cnt = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int both_cnt = 0;
  int status_reads = 0;
  int status_switch = 1000000;
  logic [7:0]  last_wen_addr = '0;
  logic [31:0] ctrl_reg = '0;
  logic        rsp_valid_d = 1'b0;
  rsp_t        exp_q[$];

  reg_if_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(1), .POLL_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .cmd_limit(cmd_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .addr(addr), .wdata(wdata), .wen(wen), .ren(ren), .rdata(rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: ctrl at ADDR_CTRL, status at ADDR_STATUS switching after status_switch reads
  always @(posedge clk) begin
    if (wen && addr == ADDR_CTRL) ctrl_reg <= wdata;
    if (ren) begin
      if (addr == ADDR_CTRL) rdata <= ctrl_reg;
      else if (addr == ADDR_STATUS) begin
        rdata <= (status_reads >= status_switch) ? 32'hA5A5A5A5 : 32'h0;
        status_reads <= status_reads + 1;
      end else rdata <= 32'h0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe counting and response scoreboard
  always @(negedge clk) begin
    if (wen) begin
      wen_cnt++;
      last_wen_addr = addr;
    end
    if (ren) ren_cnt++;
    if (wen && ren) both_cnt++;
    if (rsp_valid && !rsp_valid_d) rise_cnt++;
    rsp_valid_d = rsp_valid;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_data), 64'hDEAD);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
      hs_cyc = cyc + 1;
      hs_cnt++;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd,
                          input logic [31:0] m, input logic [15:0] lim);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_limit = lim;
    while (!cmd_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 200) check("cmd_accept_timeout", 64'(k), 64'd0);
    @(posedge clk);
    acc_cyc = cyc + 1;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n_before);
    int k = 0;
    while (hs_cnt == n_before && k < 500) begin
      @(posedge clk); k++;
    end
    check("rsp_arrived", 64'(hs_cnt != n_before), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic rsp_t mk(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  initial begin
    int n;
    logic bad;
    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'({wen, ren, rsp_valid, rsp_err}), 64'd0);
    check("rst_data", 64'({addr, wdata, rsp_data}), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Write 0xFF to ctrl
    wen_cnt = 0; ren_cnt = 0; n = hs_cnt;
    exp_q.push_back(mk(32'h0, 1'b0));
    send_cmd(OP_WR, ADDR_CTRL, 32'h000000FF, 32'h0, 16'd0);
    wait_rsp(n);
    check("wr_wen_pulses", 64'(wen_cnt), 64'd1);
    check("wr_ren_pulses", 64'(ren_cnt), 64'd0);
    check("wr_addr", 64'(last_wen_addr), 64'h00);
    check("wr_ctrl", 64'(ctrl_reg), 64'h000000FF);
    check("wr_latency", 64'(hs_cyc - acc_cyc), 64'd2);

    // Read back ctrl
    wen_cnt = 0; ren_cnt = 0; n = hs_cnt;
    exp_q.push_back(mk(32'h000000FF, 1'b0));
    send_cmd(OP_RD, ADDR_CTRL, 32'h0, 32'h0, 16'd0);
    wait_rsp(n);
    check("rd_ren_pulses", 64'(ren_cnt), 64'd1);
    check("rd_latency", 64'(hs_cyc - acc_cyc), 64'd3);

    // Poll match: status becomes 0xA5A5A5A5 on the fifth read
    ren_cnt = 0; n = hs_cnt; status_reads = 0; status_switch = 4;
    exp_q.push_back(mk(32'hA5A5A5A5, 1'b0));
    send_cmd(OP_POLL, ADDR_STATUS, 32'hA5A50000, 32'hFFFF0000, 16'd10);
    wait_rsp(n);
    check("poll_ren_pulses", 64'(ren_cnt), 64'd5);
    // RD+WAIT+CHECK = 3 per iteration, 4 gaps, response taken one edge later
    check("poll_latency", 64'(hs_cyc - acc_cyc), 64'd20);

    // Poll timeout: status stuck at 0, limit 3
    ren_cnt = 0; n = hs_cnt; status_reads = 0; status_switch = 1000000;
    exp_q.push_back(mk(32'h0, 1'b1));
    send_cmd(OP_POLL, ADDR_STATUS, 32'hA5A50000, 32'hFFFF0000, 16'd3);
    wait_rsp(n);
    check("timeout_ren_pulses", 64'(ren_cnt), 64'd4);

    // Backpressure: rsp_ready low for 5 cycles
    rsp_ready = 1'b0; n = hs_cnt; bad = 1'b0;
    exp_q.push_back(mk(32'h000000FF, 1'b0));
    send_cmd(OP_RD, ADDR_CTRL, 32'h0, 32'h0, 16'd0);
    for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'hFF || rsp_err !== 1'b0 || cmd_ready) bad = 1'b1;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_no_handshake", 64'(hs_cnt - n), 64'd0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp(n);

    // Reserved op
    wen_cnt = 0; ren_cnt = 0; n = hs_cnt;
    exp_q.push_back(mk(32'h0, 1'b1));
    send_cmd(OP_RSV, ADDR_CTRL, 32'h12345678, 32'h0, 16'd0);
    wait_rsp(n);
    check("rsv_no_strobes", 64'(wen_cnt + ren_cnt), 64'd0);

    // Reset while the read sits in WAIT
    n = hs_cnt;
    send_cmd(OP_RD, ADDR_CTRL, 32'h0, 32'h0, 16'd0);
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0; #1;
    check("mid_rst_strobes", 64'({wen, ren, rsp_valid, busy}), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_outputs", 64'({addr, rsp_data, rsp_err}), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    n = rise_cnt;
    repeat (4) @(posedge clk);
    #1 check("no_rsp_after_rst", 64'(rise_cnt - n), 64'd0);

    ren_cnt = 0; n = hs_cnt;
    exp_q.push_back(mk(32'h000000FF, 1'b0));
    send_cmd(OP_RD, ADDR_CTRL, 32'h0, 32'h0, 16'd0);
    wait_rsp(n);
    check("post_rst_rd_ren", 64'(ren_cnt), 64'd1);
    check("post_rst_latency", 64'(hs_cyc - acc_cyc), 64'd3);

    check("strobes_overlap", 64'(both_cnt), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
